// File: rtl/apb_wait_slave_pkg.sv
// Shared APB wait-slave types and constants.
// State enum, bus widths and wait counter width.
package apb_pkg;

  localparam int APB_AW = 8;
  localparam int APB_DW = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_wait_slave_if.sv
// APB completer-side bus bundle.
// Master drives PSEL/PENABLE/PWRITE/PADDR/PWDATA; slave returns PRDATA/PREADY/PSLVERR.
interface apb_wait_slave_if;
  import apb_pkg::*;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [APB_AW-1:0] PADDR;
  logic [APB_DW-1:0] PWDATA;
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_wait_slave_mem.sv
// DEPTH x 8 synchronous RAM, write-first on its single port.
// Ports: clk, we, addr, wdata, rdata (registered).
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [APB_DW-1:0] wdata,
  output logic [APB_DW-1:0] rdata
);

  logic [APB_DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/apb_wait_slave.sv
// APB completer with byte memory, fixed wait states and range error.
// Ports: PCLK, PRESET (sync, active-high), bus (slave modport).
module apb_wait_slave
  import apb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int MEM_DEPTH   = 128
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb_wait_slave_if.slave  bus
);

  localparam int MAW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_WAIT = 2'(WAIT);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [APB_AW-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [APB_DW-1:0] wdata_q, wdata_d;
  logic [APB_DW-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;

  logic              err;
  logic              commit_we;
  logic              mem_we;
  logic [APB_AW-1:0] ram_addr;
  logic [APB_DW-1:0] mem_rdata;

  assign err = {1'b0, addr_q} >= 9'(MEM_DEPTH);

  // Idle presents the live PADDR so the RAM read is
  // already valid once the access phase starts.
  assign ram_addr = (state_q == S_IDLE) ? bus.PADDR : addr_q;

  // Reset on the commit edge drops the write.
  assign mem_we = commit_we && !PRESET;

  generate
    if (MAW < APB_AW) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^ram_addr[APB_AW-1:MAW];
    end
  endgenerate

  apb_slave_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (MAW)
  ) u_mem (
    .clk   (PCLK),
    .we    (mem_we),
    .addr  (ram_addr[MAW-1:0]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    commit_we = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          addr_d  = bus.PADDR;
          wr_d    = bus.PWRITE;
          wdata_d = bus.PWDATA;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.PSEL) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          commit_we = wr_q && !err;
          if (!wr_q) begin
            prdata_d = err ? '0 : mem_rdata;
          end
          pslverr_d = err;
          pready_d  = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign bus.PRDATA  = prdata_q;
  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;

endmodule
